seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 8 +
 rtl/seq_alu_div.sv | 53 +++++
 rtl/seq_alu.sv | 138 +++++++++++++
 tb/tb_seq_alu.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: op-code and FSM state encodings shared by the sequential ALU files
package seq_alu_pkg;
  typedef enum logic [3:0] {
    OP_SLL, OP_SRA, OP_SRL, OP_MUL, OP_DIV, OP_ADD, OP_SUB, OP_AND,
    OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU, OP_MULU, OP_DIVU, OP_ZERO
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;
endpackage

// File: rtl/seq_alu_div.sv
// seq_alu_div: restoring divider, one quotient bit per cycle over operand magnitudes
module seq_alu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  logic             r_busy, r_qneg, r_rneg, w_ge;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q, r_r, r_d, w_q_n, w_r_n, w_diff;
  logic [WIDTH:0]   w_sh;
  assign w_sh      = {r_r, r_q[WIDTH-1]};
  assign w_ge      = w_sh >= {1'b0, r_d};
  assign w_diff    = w_sh[WIDTH-1:0] - r_d;
  assign w_r_n     = w_ge ? w_diff : w_sh[WIDTH-1:0];
  assign w_q_n     = {r_q[WIDTH-2:0], w_ge};
  // done flags the final iteration; results are presented from its next-state values
  assign done      = r_busy && r_cnt == CW'(WIDTH - 1);
  assign quotient  = r_qneg ? -w_q_n : w_q_n;
  assign remainder = r_rneg ? -w_r_n : w_r_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_d    <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_q    <= signed_mode && dividend[WIDTH-1] ? -dividend : dividend;
      r_d    <= signed_mode && divisor[WIDTH-1] ? -divisor : divisor;
      r_r    <= '0;
      r_qneg <= signed_mode && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_rneg <= signed_mode && dividend[WIDTH-1];
    end else if (r_busy) begin
      r_q    <= w_q_n;
      r_r    <= w_r_n;
      r_cnt  <= r_cnt + 1'b1;
      r_busy <= !done;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: ALU with single-cycle shift/logic/compare ops and WIDTH-cycle multiply/divide
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result2,
  output logic             equal,
  output logic             dbz
);
  state_e             r_state, w_state_n;
  op_e                w_op;
  logic [SHW-1:0]     r_cnt;
  logic               r_done, r_equal, r_dbz, r_eq, r_neg;
  logic [WIDTH-1:0]   r_res, r_res2, r_hi, r_lo, r_mc;
  logic [WIDTH-1:0]   w_res, w_res2, w_hi_n, w_lo_n, w_quo, w_rem;
  logic               w_dbz, w_accept, w_last, w_is_mul, w_is_div, w_sgn, w_div_done;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  assign w_op     = op_e'(op);
  assign w_accept = start && r_state == S_IDLE;
  assign w_last   = r_cnt == SHW'(WIDTH - 1);
  assign w_is_mul = w_op == OP_MUL || w_op == OP_MULU;
  assign w_is_div = (w_op == OP_DIV || w_op == OP_DIVU) && y != '0;
  assign w_sgn    = w_op == OP_MUL;
  // shift-add step: {r_hi, r_lo} shifts right while r_lo drains the multiplier bits
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mc} : '0);
  assign w_hi_n   = w_sum[WIDTH:1];
  assign w_lo_n   = {w_sum[0], r_lo[WIDTH-1:1]};
  assign w_prod   = r_neg ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};
  assign busy     = r_state != S_IDLE;
  assign done     = r_done;
  assign result   = r_res;
  assign result2  = r_res2;
  assign equal    = r_equal;
  assign dbz      = r_dbz;
  seq_alu_div #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (w_accept && w_is_div),
    .dividend   (x),
    .divisor    (y),
    .signed_mode(w_op == OP_DIV),
    .quotient   (w_quo),
    .remainder  (w_rem),
    .done       (w_div_done)
  );
  // single-cycle results; the DIV/DIVU arm only matters for the divide-by-zero case
  always_comb begin
    w_res  = '0;
    w_res2 = '0;
    w_dbz  = 1'b0;
    case (w_op)
      OP_SLL:          w_res = x << shamt;
      OP_SRA:          w_res = $signed(x) >>> shamt;
      OP_SRL:          w_res = x >> shamt;
      OP_DIV, OP_DIVU: begin
        w_res  = '1;
        w_res2 = x;
        w_dbz  = 1'b1;
      end
      OP_ADD:          w_res = x + y;
      OP_SUB:          w_res = x - y;
      OP_AND:          w_res = x & y;
      OP_OR:           w_res = x | y;
      OP_XOR:          w_res = x ^ y;
      OP_NOR:          w_res = ~(x | y);
      OP_SLT:          w_res = WIDTH'($signed(x) < $signed(y));
      OP_SLTU:         w_res = WIDTH'(x < y);
      default:         w_res = '0;
    endcase
  end
  always_comb begin
    w_state_n = r_state;
    if (r_state == S_IDLE && w_accept) w_state_n = w_is_mul ? S_MUL : w_is_div ? S_DIV : S_IDLE;
    else if (r_state != S_IDLE && w_last) w_state_n = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_res   <= '0;
      r_res2  <= '0;
      r_equal <= 1'b0;
      r_dbz   <= 1'b0;
      r_eq    <= 1'b0;
      r_neg   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mc    <= '0;
    end else begin
      r_state <= w_state_n;
      r_done  <= 1'b0;
      r_cnt   <= (r_state == S_IDLE || w_last) ? '0 : r_cnt + 1'b1;
      if (w_accept) begin
        r_eq  <= x == y;
        r_hi  <= '0;
        r_lo  <= w_sgn && y[WIDTH-1] ? -y : y;
        r_mc  <= w_sgn && x[WIDTH-1] ? -x : x;
        r_neg <= w_sgn && (x[WIDTH-1] ^ y[WIDTH-1]);
        if (!w_is_mul && !w_is_div) begin
          r_res   <= w_res;
          r_res2  <= w_res2;
          r_dbz   <= w_dbz;
          r_equal <= x == y;
          r_done  <= 1'b1;
        end
      end else if (r_state == S_MUL) begin
        r_hi <= w_hi_n;
        r_lo <= w_lo_n;
        if (w_last) begin
          {r_res2, r_res} <= w_prod;
          r_dbz   <= 1'b0;
          r_equal <= r_eq;
          r_done  <= 1'b1;
        end
      end else if (w_div_done) begin
        r_res   <= w_quo;
        r_res2  <= w_rem;
        r_dbz   <= 1'b0;
        r_equal <= r_eq;
        r_done  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu at WIDTH=32 and WIDTH=16
module tb_seq_alu;
  import seq_alu_pkg::*;
  typedef struct packed {
    logic [31:0] r;
    logic [31:0] r2;
    logic        eq;
    logic        dbz;
    int          lat;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0, st32 = 1'b0, st16 = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] x = '0, y = '0;
  logic [4:0]  sh = '0;
  logic        busy32, done32, eq32, dbz32, busy16, done16, eq16, dbz16;
  logic [31:0] r32, r2_32;
  logic [15:0] r16, r2_16;
  exp_t        q32[$], q16[$];
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;
  seq_alu dut32 (
    .clk(clk), .rst_n(rst_n), .start(st32), .op(op), .x(x), .y(y), .shamt(sh),
    .busy(busy32), .done(done32), .result(r32), .result2(r2_32), .equal(eq32), .dbz(dbz32)
  );
  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .op(op), .x(x[15:0]), .y(y[15:0]), .shamt(sh[3:0]),
    .busy(busy16), .done(done16), .result(r16), .result2(r2_16), .equal(eq16), .dbz(dbz16)
  );
  // reference model built on native 64-bit arithmetic, masked to w bits
  function automatic exp_t model(int w, logic [3:0] o, logic [31:0] a, logic [31:0] b, int s);
    exp_t e;
    longint sa, sb, res, res2;
    longint unsigned ua, ub, m;
    m    = (64'd1 << w) - 1;
    ua   = a & m;
    ub   = b & m;
    sa   = w == 32 ? longint'($signed(a)) : longint'($signed(a[15:0]));
    sb   = w == 32 ? longint'($signed(b)) : longint'($signed(b[15:0]));
    e    = '0;
    e.eq = ua == ub;
    e.lat = 1;
    res  = 0;
    res2 = 0;
    case (o)
      4'd0:  res = ua << s;
      4'd1:  res = sa >>> s;
      4'd2:  res = ua >> s;
      4'd3:  begin res = sa * sb; res2 = res >>> w; e.lat = w + 1; end
      4'd4:  if (ub == 0) begin res = m; res2 = ua; e.dbz = 1; end
             else begin res = sa / sb; res2 = sa % sb; e.lat = w + 1; end
      4'd5:  res = ua + ub;
      4'd6:  res = ua - ub;
      4'd7:  res = ua & ub;
      4'd8:  res = ua | ub;
      4'd9:  res = ua ^ ub;
      4'd10: res = ~(ua | ub);
      4'd11: res = sa < sb;
      4'd12: res = ua < ub;
      4'd13: begin res = ua * ub; res2 = res >> w; e.lat = w + 1; end
      4'd14: if (ub == 0) begin res = m; res2 = ua; e.dbz = 1; end
             else begin res = ua / ub; res2 = ua % ub; e.lat = w + 1; end
      default: res = 0;
    endcase
    e.r  = 32'(res & m);
    e.r2 = 32'(res2 & m);
    return e;
  endfunction
  // called at a negedge; start is high for exactly one edge, then operands are scrambled
  task automatic issue(int w, logic [3:0] o, logic [31:0] a, logic [31:0] b, int s);
    op = o;
    x  = a;
    y  = b;
    sh = 5'(s);
    if (w == 32) begin st32 = 1'b1; q32.push_back(model(32, o, a, b, s)); end
    else begin st16 = 1'b1; q16.push_back(model(16, o, a, b, s)); end
    @(negedge clk);
    st32 = 1'b0;
    st16 = 1'b0;
    x  = $urandom;
    y  = $urandom;
    op = 4'($urandom_range(0, 15));
  endtask
  // waits for done, optionally pokes start at cycle poke while busy, then scores the result
  task automatic drain(int w, int poke);
    exp_t e;
    int n = 1, bc = 0;
    logic d, b;
    logic [31:0] gr, gr2;
    while (n < 200) begin
      d = w == 32 ? done32 : done16;
      b = w == 32 ? busy32 : busy16;
      if (d) break;
      if (b) bc++;
      if (n == poke) begin
        op = OP_ADD;
        if (w == 32) st32 = 1'b1; else st16 = 1'b1;
      end else begin
        st32 = 1'b0;
        st16 = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    st32 = 1'b0;
    st16 = 1'b0;
    if (w == 32) e = q32.pop_front(); else e = q16.pop_front();
    checks++;
    if (!d) begin
      failures++;
      $display("FAIL done_timeout w=%0d got=no_done exp=done_at_%0d", w, e.lat);
      return;
    end
    gr  = w == 32 ? r32 : {16'b0, r16};
    gr2 = w == 32 ? r2_32 : {16'b0, r2_16};
    checks += 7;
    if (n !== e.lat) begin failures++; $display("FAIL latency w=%0d got=%0d exp=%0d", w, n, e.lat); end
    if (bc !== e.lat - 1) begin failures++; $display("FAIL busy_cycles w=%0d got=%0d exp=%0d", w, bc, e.lat - 1); end
    if (b !== 1'b0) begin failures++; $display("FAIL busy_at_done w=%0d got=%b exp=0", w, b); end
    if (gr !== e.r) begin failures++; $display("FAIL result w=%0d got=%h exp=%h", w, gr, e.r); end
    if (gr2 !== e.r2) begin failures++; $display("FAIL result2 w=%0d got=%h exp=%h", w, gr2, e.r2); end
    if ((w == 32 ? eq32 : eq16) !== e.eq) begin failures++; $display("FAIL equal w=%0d exp=%b", w, e.eq); end
    if ((w == 32 ? dbz32 : dbz16) !== e.dbz) begin failures++; $display("FAIL dbz w=%0d exp=%b", w, e.dbz); end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 2;
    if ({busy32, done32, r32, r2_32, eq32, dbz32} !== '0) begin
      failures++;
      $display("FAIL reset32 got=%b%b %h %h %b%b exp=0", busy32, done32, r32, r2_32, eq32, dbz32);
    end
    if ({busy16, done16, r16, r2_16, eq16, dbz16} !== '0) begin
      failures++;
      $display("FAIL reset16 got=%b%b %h %h %b%b exp=0", busy16, done16, r16, r2_16, eq16, dbz16);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_single();
    int ops[12] = '{0, 1, 2, 5, 6, 7, 8, 9, 10, 11, 12, 15};
    issue(32, OP_ADD, 32'h7FFF_FFFF, 32'h1, 0);
    drain(32, 0);
    issue(32, OP_SRA, 32'h8000_0000, 32'h0, 31);
    drain(32, 0);
    issue(32, OP_XOR, 32'h1234_5678, 32'h1234_5678, 0);
    drain(32, 0);
    foreach (ops[i]) begin
      issue(32, 4'(ops[i]), $urandom, $urandom, $urandom_range(0, 31));
      drain(32, 0);
    end
  endtask
  task automatic test_mul();
    issue(32, OP_MUL, -32'sd3, 32'sd7, 0);
    drain(32, 0);
    issue(32, OP_MUL, 32'h8000_0000, 32'h8000_0000, 0);
    drain(32, 0);
    issue(32, OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    drain(32, 0);
    repeat (3) begin
      issue(32, OP_MUL, $urandom, $urandom, 0);
      drain(32, 0);
      issue(32, OP_MULU, $urandom, $urandom, 0);
      drain(32, 0);
    end
  endtask
  task automatic test_div();
    issue(32, OP_DIV, -32'sd7, 32'sd2, 0);
    drain(32, 0);
    issue(32, OP_DIVU, 32'hFFFF_FFF9, 32'h2, 0);
    drain(32, 0);
    issue(32, OP_DIV, 32'h5, 32'h0, 0);
    drain(32, 0);
    issue(32, OP_DIVU, 32'hDEAD_BEEF, 32'h0, 0);
    drain(32, 0);
    issue(32, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    drain(32, 0);
    repeat (3) begin
      issue(32, OP_DIV, $urandom, 32'($urandom_range(1, 5000)) * (($urandom & 1) != 0 ? -1 : 1), 0);
      drain(32, 0);
      issue(32, OP_DIVU, $urandom, $urandom >> $urandom_range(0, 28), 0);
      drain(32, 0);
    end
  endtask
  task automatic test_back_to_back();
    issue(32, OP_MUL, 32'h1234, 32'h5678, 0);
    drain(32, 5);
    checks++;
    repeat (3) begin
      @(negedge clk);
      if (done32 !== 1'b0) begin failures++; $display("FAIL ignored_start got=done exp=idle"); break; end
    end
    issue(32, OP_DIVU, 32'd1000, 32'd7, 0);
    drain(32, 0);
    issue(32, OP_SUB, 32'd3, 32'd10, 0);
    drain(32, 0);
    issue(32, OP_MULU, 32'hABCD, 32'h1234, 0);
    drain(32, 0);
    issue(32, OP_SLTU, 32'd1, 32'hFFFF_FFFF, 0);
    drain(32, 0);
  endtask
  task automatic test_abort();
    bit seen = 1'b0;
    issue(32, OP_MUL, 32'h55, 32'h66, 0);
    void'(q32.pop_front());
    for (int n = 1; n < 10; n++) begin
      st32 = n == 3;
      if (done32) seen = 1'b1;
      @(negedge clk);
    end
    st32  = 1'b0;
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (seen) begin failures++; $display("FAIL abort_done got=done exp=none"); end
    if ({busy32, done32, r32, r2_32, eq32, dbz32} !== '0) begin
      failures++;
      $display("FAIL abort_clear got=%b%b %h %h %b%b exp=0", busy32, done32, r32, r2_32, eq32, dbz32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32, OP_SRA, 32'h8000_0000, 32'h0, 4);
    drain(32, 0);
  endtask
  task automatic test_w16();
    @(negedge clk);
    issue(16, OP_MUL, 32'hFFFF_FFFD, 32'd7, 0);
    drain(16, 0);
    issue(16, OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    drain(16, 0);
    issue(16, OP_DIVU, 32'h0000_FFF9, 32'd2, 0);
    drain(16, 0);
    issue(16, OP_MULU, 32'h0000_FFFF, 32'h0000_FFFF, 0);
    drain(16, 0);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_single();
    test_mul();
    test_div();
    test_back_to_back();
    test_abort();
    test_w16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
